// File: rtl/kronos_mtimer.sv
// kronos_mtimer: machine timer (mtime/mtimecmp/msip) with a single-cycle-ack
// Wishbone-style slave port. Produces the level timer and software interrupts
// consumed by kronos_csr; masking is left to the CSR block.
module kronos_mtimer #(
    parameter int unsigned PRESCALE       = 1,
    parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    input  logic        we,
    input  logic        cyc,
    input  logic        stb,
    output logic        ack,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam logic [0:0]  IDLE     = 1'b0;
    localparam logic [0:0]  ACK      = 1'b1;
    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    localparam logic [2:0] W_MTIME_LO = 3'd0;
    localparam logic [2:0] W_MTIME_HI = 3'd1;
    localparam logic [2:0] W_CMP_LO   = 3'd2;
    localparam logic [2:0] W_CMP_HI   = 3'd3;
    localparam logic [2:0] W_MSIP     = 3'd4;

    logic [0:0]  state;
    logic [15:0] pre_cnt;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;
    logic        req;
    logic        wr;
    logic [2:0]  word;
    logic [31:0] rd_mux;
    logic        unused_addr_bits;

    // A request is only sampled from IDLE; a stb still held during ACK is ignored.
    assign req  = cyc & stb & (state == IDLE);
    assign wr   = req & we;
    assign word = addr[4:2];
    assign tick = (pre_cnt == PRE_LAST);

    assign ack                = (state == ACK);
    assign software_interrupt = msip;
    assign unused_addr_bits   = ^{addr[31:5], addr[1:0]};

    // Bus handshake: one ACK cycle per sampled request.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (cyc & stb) state <= ACK;
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaler: counts 0..PRESCALE-1, tick on the last count.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 16'd1;
        end
    end

    // mtime: half-word loads win over the tick increment of the same cycle.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            mtime <= '0;
        end else if (wr && (word == W_MTIME_LO)) begin
            mtime[31:0] <= wr_data;
        end else if (wr && (word == W_MTIME_HI)) begin
            mtime[63:32] <= wr_data;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp: independent half-word loads.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            mtimecmp <= MTIMECMP_RESET;
        end else if (wr && (word == W_CMP_LO)) begin
            mtimecmp[31:0] <= wr_data;
        end else if (wr && (word == W_CMP_HI)) begin
            mtimecmp[63:32] <= wr_data;
        end
    end

    // msip: single software-interrupt pending bit.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            msip <= 1'b0;
        end else if (wr && (word == W_MSIP)) begin
            msip <= wr_data[0];
        end
    end

    // Read mux over pre-edge register values; unmapped words read zero.
    always_comb begin
        rd_mux = '0;
        case (word)
            W_MTIME_LO: rd_mux = mtime[31:0];
            W_MTIME_HI: rd_mux = mtime[63:32];
            W_CMP_LO:   rd_mux = mtimecmp[31:0];
            W_CMP_HI:   rd_mux = mtimecmp[63:32];
            W_MSIP:     rd_mux = {31'd0, msip};
            default:    rd_mux = '0;
        endcase
    end

    // Read data captured on the edge that enters ACK.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            rd_data <= '0;
        end else if (req) begin
            rd_data <= rd_mux;
        end
    end

    // Registered compare: one cycle behind any mtime/mtimecmp change.
    always_ff @(posedge clk) begin
        if (!rstz) begin
            timer_interrupt <= 1'b0;
        end else begin
            timer_interrupt <= (mtime >= mtimecmp);
        end
    end

endmodule
